// File: rtl/sme_driver.sv
// Buffers upstream string/pattern frames, replays them to the SME one character
// per cycle, then waits for the SME result (or a timeout) and reports it once.
module sme_driver #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_kind,
  input  logic       in_last,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       valid,
  input  logic       match,
  input  logic [4:0] match_index,
  output logic       res_valid,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_timeout,
  output logic       res_ovf,
  output logic [2:0] dbg_state_o
);

  localparam int MAXL = (STR_MAX > PAT_MAX) ? STR_MAX : PAT_MAX;
  localparam int CW   = $clog2(MAXL + 1);
  localparam int SAW  = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;
  localparam int PAW  = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
  localparam logic [CW-1:0] STR_L   = CW'(STR_MAX);
  localparam logic [CW-1:0] PAT_L   = CW'(PAT_MAX);
  localparam logic [15:0]   TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_STR, S_SEND_PAT, S_WAIT, S_REPORT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] str_len_q, str_len_d;
  logic [CW-1:0] pat_len_q, pat_len_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          infrm_q, infrm_d;
  logic          kind_q, kind_d;
  logic          res_match_q, res_match_d;
  logic [4:0]    res_index_q, res_index_d;
  logic          res_timeout_q, res_timeout_d;
  logic          res_ovf_q, res_ovf_d;

  logic [7:0]    str_mem [STR_MAX];
  logic [7:0]    pat_mem [PAT_MAX];

  logic          str_we, pat_we, beat_kind;
  logic [CW-1:0] wr_addr;
  logic          ready, send_str, send_pat, rv;
  logic [7:0]    send_char;

  // Handshake: a character transfers on a rising edge where in_valid and
  // in_ready are both high; in_ready depends only on state, never on in_valid.
  always_comb begin
    state_d       = state_q;
    str_len_d     = str_len_q;
    pat_len_d     = pat_len_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    ovf_d         = ovf_q;
    infrm_d       = infrm_q;
    kind_d        = kind_q;
    res_match_d   = res_match_q;
    res_index_d   = res_index_q;
    res_timeout_d = res_timeout_q;
    res_ovf_d     = res_ovf_q;
    str_we        = 1'b0;
    pat_we        = 1'b0;
    wr_addr       = '0;
    ready         = 1'b0;
    send_str      = 1'b0;
    send_pat      = 1'b0;
    send_char     = 8'h00;
    rv            = 1'b0;
    // Frame kind is latched from the first beat; later beats ignore in_kind.
    beat_kind     = infrm_q ? kind_q : in_kind;

    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (in_valid) begin
          infrm_d = !in_last;
          kind_d  = beat_kind;
          if (!beat_kind) begin
            if (!infrm_q) begin
              str_we    = 1'b1;
              str_len_d = CW'(1);
            end else if (str_len_q < STR_L) begin
              str_we    = 1'b1;
              wr_addr   = str_len_q;
              str_len_d = str_len_q + 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end else begin
            if (!infrm_q) begin
              pat_we    = 1'b1;
              pat_len_d = CW'(1);
            end else if (pat_len_q < PAT_L) begin
              pat_we    = 1'b1;
              wr_addr   = pat_len_q;
              pat_len_d = pat_len_q + 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
          if (in_last) begin
            idx_d   = '0;
            state_d = beat_kind ? S_SEND_PAT : S_SEND_STR;
          end
        end
      end
      S_SEND_STR: begin
        send_str  = 1'b1;
        send_char = str_mem[idx_q[SAW-1:0]];
        idx_d     = idx_q + 1'b1;
        if (idx_q + 1'b1 == str_len_q) state_d = S_IDLE;
      end
      S_SEND_PAT: begin
        send_pat  = 1'b1;
        send_char = pat_mem[idx_q[PAW-1:0]];
        idx_d     = idx_q + 1'b1;
        if (idx_q + 1'b1 == pat_len_q) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (valid) begin
          res_match_d   = match;
          res_index_d   = match_index;
          res_timeout_d = 1'b0;
          res_ovf_d     = ovf_q;
          state_d       = S_REPORT;
        end else if (cnt_q == TO_LAST) begin
          res_match_d   = 1'b0;
          res_index_d   = '0;
          res_timeout_d = 1'b1;
          res_ovf_d     = ovf_q;
          state_d       = S_REPORT;
        end
      end
      S_REPORT: begin
        rv      = 1'b1;
        ovf_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      str_len_q     <= '0;
      pat_len_q     <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      ovf_q         <= 1'b0;
      infrm_q       <= 1'b0;
      kind_q        <= 1'b0;
      res_match_q   <= 1'b0;
      res_index_q   <= '0;
      res_timeout_q <= 1'b0;
      res_ovf_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      str_len_q     <= str_len_d;
      pat_len_q     <= pat_len_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      ovf_q         <= ovf_d;
      infrm_q       <= infrm_d;
      kind_q        <= kind_d;
      res_match_q   <= res_match_d;
      res_index_q   <= res_index_d;
      res_timeout_q <= res_timeout_d;
      res_ovf_q     <= res_ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (str_we) str_mem[wr_addr[SAW-1:0]] <= in_data;
    if (pat_we) pat_mem[wr_addr[PAW-1:0]] <= in_data;
  end

  // Outputs are forced low while reset is held, even before the first edge.
  assign in_ready    = ready & ~reset;
  assign chardata    = reset ? 8'h00 : send_char;
  assign isstring    = send_str & ~reset;
  assign ispattern   = send_pat & ~reset;
  assign res_valid   = rv & ~reset;
  assign res_match   = res_match_q & ~reset;
  assign res_index   = reset ? 5'd0 : res_index_q;
  assign res_timeout = res_timeout_q & ~reset;
  assign res_ovf     = res_ovf_q & ~reset;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sme_driver.sv
// Bench for sme_driver: table-driven frames plus reset corner sequences, with
// character and result scoreboards fed by the driver and drained by a monitor.
module tb_sme_driver;

  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 8;
  localparam int TIMEOUT = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_kind = 1'b0;
  logic       in_last = 1'b0;
  logic [7:0] chardata;
  logic       isstring, ispattern;
  logic       valid = 1'b0;
  logic       match = 1'b0;
  logic [4:0] match_index = 5'd0;
  logic       res_valid, res_match, res_timeout, res_ovf;
  logic [4:0] res_index;
  logic [2:0] dbg_state;

  sme_driver #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_kind(in_kind), .in_last(in_last),
    .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
    .valid(valid), .match(match), .match_index(match_index),
    .res_valid(res_valid), .res_match(res_match), .res_index(res_index),
    .res_timeout(res_timeout), .res_ovf(res_ovf), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        m;
    logic [4:0]  ix;
    logic        to;
    logic        ovf;
    logic [15:0] lat;
  } res_t;

  logic [8:0] exp_q[$];   // {is_pattern, char}
  res_t       res_q[$];
  int         checks = 0;
  int         errors = 0;
  logic       sticky_ovf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  logic [8:0] mon_e;
  res_t       mon_r;
  logic       prev_pat = 1'b0;
  int         wait_start = 0;

  always @(negedge clk) begin
    if (reset) begin
      check("reset_outputs", {in_ready, chardata, isstring, ispattern, res_valid,
                              res_match, res_index, res_timeout, res_ovf}, 32'd0);
      prev_pat = 1'b0;
    end else begin
      if (isstring || ispattern) begin
        check("ready_low_in_send", {31'd0, in_ready}, 32'd0);
        if (exp_q.size() == 0) fail_now("unexpected_char");
        else begin
          mon_e = exp_q.pop_front();
          check("char", {ispattern, isstring, chardata}, {mon_e[8], ~mon_e[8], mon_e[7:0]});
        end
      end else begin
        check("idle_char", {24'd0, chardata}, 32'd0);
      end
      if (prev_pat && !ispattern) wait_start = cyc;
      prev_pat = ispattern;
      if (res_valid) begin
        if (res_q.size() == 0) fail_now("unexpected_res_valid");
        else begin
          mon_r = res_q.pop_front();
          check("res_match",   {31'd0, res_match},   {31'd0, mon_r.m});
          check("res_index",   {27'd0, res_index},   {27'd0, mon_r.ix});
          check("res_timeout", {31'd0, res_timeout}, {31'd0, mon_r.to});
          check("res_ovf",     {31'd0, res_ovf},     {31'd0, mon_r.ovf});
          check("res_latency", cyc - wait_start,     {16'd0, mon_r.lat});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [7:0] fbuf [64];

  // Tasks start and end just after a rising edge.
  task automatic send_frame(input logic kind, input int len);
    for (int i = 0; i < len; i++) begin
      int g = $urandom_range(0, 2);
      repeat (g) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_kind  = 1'($urandom);
        in_last  = 1'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = fbuf[i];
      in_kind  = (i == 0) ? kind : 1'($urandom);
      in_last  = (i == len - 1);
      begin
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin @(negedge clk); t++; end
        if (!in_ready) fail_now("driver_accept_timeout");
        else if (!kind && i < STR_MAX) exp_q.push_back({1'b0, fbuf[i]});
        else if (kind && i < PAT_MAX) exp_q.push_back({1'b1, fbuf[i]});
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Returns at the falling edge of the first WAIT cycle.
  task automatic wait_pattern_done();
    int t = 0;
    @(negedge clk);
    while (!ispattern && t < 500) begin @(negedge clk); t++; end
    while (ispattern && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) fail_now("pattern_send_timeout");
  endtask

  task automatic sme_respond(input int delay, input logic m, input logic [4:0] ix);
    wait_pattern_done();
    repeat (delay) @(negedge clk);
    valid = 1'b1; match = m; match_index = ix;
    @(negedge clk);
    valid = 1'b0; match = 1'b0; match_index = 5'd0;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || res_q.size() != 0) && t < TIMEOUT + 200) begin
      @(posedge clk); t++;
    end
    if (t >= TIMEOUT + 200) begin
      fail_now("drain_timeout");
      exp_q.delete();
      res_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input logic m, input logic [4:0] ix, input logic to,
                            input logic ovf, input int lat);
    res_t r;
    r.m = m; r.ix = ix; r.to = to; r.ovf = ovf; r.lat = 16'(lat);
    res_q.push_back(r);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        kind;
    logic [95:0] txt;
    int          len;
    int          resp;
    int          delay;
    logic        m;
    logic [4:0]  ix;
    logic        e_m;
    logic [4:0]  e_ix;
    logic        e_to;
    logic        e_ovf;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, "abc",        3,  0, 0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0};
    vecs[1] = '{1'b0, "hello",      5,  0, 0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0};
    vecs[2] = '{1'b1, "ll",         2,  1, 3,  1'b1, 5'd2,  1'b1, 5'd2,  1'b0, 1'b0};
    vecs[3] = '{1'b1, "abcdefghij", 10, 1, 0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1};
    vecs[4] = '{1'b1, "xy",         2,  1, 1,  1'b1, 5'd17, 1'b1, 5'd17, 1'b0, 1'b0};
    vecs[5] = '{1'b1, "q",          1,  0, 0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 1'b0};
    vecs[6] = '{1'b1, "zz",         2,  1, TIMEOUT - 1, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0};
    vecs[7] = '{1'b1, "k",          1,  1, TIMEOUT,     1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 1'b0};
    vecs[8] = '{1'b0, "Zy",         2,  0, 0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0};

    // reset phase
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {31'd0, in_ready}, 32'd1);
    check("res_after_reset", {res_valid, res_match, res_index, res_timeout, res_ovf}, 32'd0);
    @(posedge clk); #1;

    // table-driven frames
    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < vecs[v].len; i++)
        fbuf[i] = vecs[v].txt[8 * (vecs[v].len - 1 - i) +: 8];
      if (vecs[v].kind) begin
        expect_res(vecs[v].e_m, vecs[v].e_ix, vecs[v].e_to, vecs[v].e_ovf,
                   (vecs[v].resp != 0 && vecs[v].delay < TIMEOUT) ? vecs[v].delay + 1 : TIMEOUT);
        sticky_ovf = 1'b0;
      end
      send_frame(vecs[v].kind, vecs[v].len);
      if (vecs[v].kind && vecs[v].resp != 0)
        sme_respond(vecs[v].delay, vecs[v].m, vecs[v].ix);
      wait_idle();
    end

    // reset on the second SEND_STR cycle
    fbuf[0] = "r"; fbuf[1] = "s"; fbuf[2] = "t"; fbuf[3] = "!";
    send_frame(1'b0, 4);
    begin
      int t = 0;
      @(negedge clk);
      while (!isstring && t < 100) begin @(negedge clk); t++; end
      if (!isstring) fail_now("send_str_start_timeout");
    end
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_abort", {31'd0, in_ready}, 32'd1);
    repeat (6) @(posedge clk);
    #1;

    // string overflow sets sticky ovf; reset in WAIT aborts and clears it
    for (int i = 0; i < 36; i++) fbuf[i] = 8'($urandom_range(32, 126));
    send_frame(1'b0, 36);
    sticky_ovf = 1'b1;
    wait_idle();
    fbuf[0] = "p"; fbuf[1] = "q";
    send_frame(1'b1, 2);
    wait_pattern_done();
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    sticky_ovf = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (TIMEOUT + 10) @(posedge clk);
    #1;
    fbuf[0] = "a"; fbuf[1] = "b";
    expect_res(1'b1, 5'd3, 1'b0, 1'b0, 3);
    send_frame(1'b1, 2);
    sme_respond(2, 1'b1, 5'd3);
    wait_idle();

    // random frames with gaps; ovf predicted from frame lengths
    for (int f = 0; f < 10; f++) begin
      logic       k = 1'($urandom);
      int         len = k ? $urandom_range(1, 12) : $urandom_range(1, 40);
      int         d = $urandom_range(0, 6);
      logic       m = 1'($urandom);
      logic [4:0] ix = 5'($urandom);
      logic       fo = k ? (len > PAT_MAX) : (len > STR_MAX);
      for (int i = 0; i < len; i++) fbuf[i] = 8'($urandom_range(32, 126));
      if (k) begin
        expect_res(m, ix, 1'b0, sticky_ovf | fo, d + 1);
        sticky_ovf = 1'b0;
      end else begin
        sticky_ovf = sticky_ovf | fo;
      end
      send_frame(k, len);
      if (k) sme_respond(d, m, ix);
      wait_idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
